// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: feeds operand pairs into one DSP slice, sequences OPMODE so
// that every N_TAPS products form one accumulated dot product, and returns each
// finished 48-bit sum on a valid/ready result stream.
//
// The slice is configured with A1REG/B1REG/MREG/PREG/OPMODEREG = 1. This block
// adds one issue register and one OPMODE register in front of it. A one-bit
// "done" tag runs alongside so that it lines up with the cycle in which DSP_P
// holds the finished sum. A full result register combined with a new sum
// arriving freezes the whole pipeline, including the slice through DSP_CE.
module dsp_mac_sequencer #(
   parameter int N_TAPS = 8,
   parameter int CNT_W  = 10
) (
   input  logic        CLK,
   input  logic        RSTN,
   input  logic        S_VALID,
   output logic        S_READY,
   input  logic [17:0] S_A,
   input  logic [17:0] S_B,
   output logic        R_VALID,
   input  logic        R_READY,
   output logic [47:0] R_DATA,
   output logic [17:0] DSP_A,
   output logic [17:0] DSP_B,
   output logic [7:0]  DSP_OPMODE,
   output logic        DSP_CE,
   input  logic [47:0] DSP_P
);

   // OPMODE encodings: X = bits[1:0] (01 = M), Z = bits[3:2] (10 = P).
   localparam logic [7:0] OPM_FIRST = 8'h01;   // P = M
   localparam logic [7:0] OPM_ACC   = 8'h09;   // P = P + M
   localparam logic [7:0] OPM_HOLD  = 8'h08;   // P = P
   localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(N_TAPS - 1);

   // Tag that travels with each issued pair.
   typedef struct packed {
      logic vld;
      logic first;
      logic last;
   } tag_t;

   logic [CNT_W-1:0] tap_cnt_q, tap_cnt_d;
   logic [17:0]      iss_a_q, iss_a_d;
   logic [17:0]      iss_b_q, iss_b_d;
   tag_t             iss_tag_q, iss_tag_d;
   logic [7:0]       opmode_q, opmode_d;
   logic             done1_q, done1_d;
   logic             done2_q, done2_d;
   logic             done3_q, done3_d;
   logic             r_valid_q, r_valid_d;
   logic [47:0]      r_data_q, r_data_d;

   logic stall;
   logic accept;
   logic capture;

   // Handshake and slice enable; RSTN is folded in so that both read 0 while in reset.
   always_comb begin
      stall   = done3_q && r_valid_q && !R_READY;
      S_READY = RSTN && !stall;
      DSP_CE  = RSTN && !stall;
      accept  = S_VALID && S_READY;
      capture = done3_q && !stall;
   end

   // Next-state logic for the issue, OPMODE, done and result registers.
   always_comb begin
      // NOTE: every output of this block is assigned a default first, so no path can leave a value unassigned and infer a latch.
      tap_cnt_d = tap_cnt_q;
      iss_a_d   = iss_a_q;
      iss_b_d   = iss_b_q;
      iss_tag_d = iss_tag_q;
      opmode_d  = opmode_q;
      done1_d   = done1_q;
      done2_d   = done2_q;
      done3_d   = done3_q;
      r_valid_d = r_valid_q;
      r_data_d  = r_data_q;

      if (!stall) begin
         // Issue stage: a pair or a zero bubble.
         iss_a_d         = accept ? S_A : 18'd0;
         iss_b_d         = accept ? S_B : 18'd0;
         iss_tag_d.vld   = accept;
         iss_tag_d.first = accept && (tap_cnt_q == '0);
         iss_tag_d.last  = accept && (tap_cnt_q == LAST_TAP);
         if (accept) begin
            tap_cnt_d = (tap_cnt_q == LAST_TAP) ? '0 : tap_cnt_q + CNT_W'(1);
         end

         // OPMODE follows the issue tag by one cycle, which matches the slice's A1/B1 stage.
         if (!iss_tag_q.vld) begin
            opmode_d = OPM_HOLD;
         end else if (iss_tag_q.first) begin
            opmode_d = OPM_FIRST;
         end else begin
            opmode_d = OPM_ACC;
         end

         // done3 lines up with P holding the finished sum.
         done1_d = iss_tag_q.vld && iss_tag_q.last;
         done2_d = done1_q;
         done3_d = done2_q;
      end

      // Result register: a capture takes priority over a drain in the same cycle.
      if (capture) begin
         r_data_d  = DSP_P;
         r_valid_d = 1'b1;
      end else if (r_valid_q && R_READY) begin
         r_valid_d = 1'b0;
      end
   end

   // State registers; reset discards any partial vector.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         // NOTE: registers use non-blocking assignments so that every flop samples the pre-edge values.
         tap_cnt_q <= '0;
         iss_a_q   <= '0;
         iss_b_q   <= '0;
         iss_tag_q <= '0;
         opmode_q  <= '0;
         done1_q   <= 1'b0;
         done2_q   <= 1'b0;
         done3_q   <= 1'b0;
         r_valid_q <= 1'b0;
         r_data_q  <= '0;
      end else begin
         tap_cnt_q <= tap_cnt_d;
         iss_a_q   <= iss_a_d;
         iss_b_q   <= iss_b_d;
         iss_tag_q <= iss_tag_d;
         opmode_q  <= opmode_d;
         done1_q   <= done1_d;
         done2_q   <= done2_d;
         done3_q   <= done3_d;
         r_valid_q <= r_valid_d;
         r_data_q  <= r_data_d;
      end
   end

   assign DSP_A      = iss_a_q;
   assign DSP_B      = iss_b_q;
   assign DSP_OPMODE = opmode_q;
   assign R_VALID    = r_valid_q;
   assign R_DATA     = r_data_q;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// tb_dsp_mac_sequencer: directed test of the MAC sequencer. Three instances
// (N_TAPS = 4, 2 and 1) each drive a behavioural DSP slice model. All instances
// share the stimulus, and each test checks one of them.
module tb_dsp_mac_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        s_valid;
   logic [17:0] s_a;
   logic [17:0] s_b;
   logic        r_ready;

   logic        s_ready_w [3];
   logic        r_valid_w [3];
   logic [47:0] r_data_w  [3];
   logic [17:0] dsp_a_w   [3];
   logic [17:0] dsp_b_w   [3];
   logic [7:0]  dsp_op_w  [3];
   logic        dsp_ce_w  [3];

   int          sel = 0;
   int          cyc = 0;
   int          last_acc = 0;
   int          n_total = 0;
   int          n_bad = 0;
   logic [47:0] got_q[$];
   int          got_cyc[$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // DUT instances, each paired with a slice model
   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int NT = (g == 0) ? 4 : ((g == 1) ? 2 : 1);
      logic        s_ready_l, r_valid_l, ce_l;
      logic [47:0] r_data_l;
      logic [17:0] a_l, b_l;
      logic [7:0]  op_l;
      logic [17:0] a1 = '0;
      logic [17:0] b1 = '0;
      logic [35:0] m  = '0;
      logic [7:0]  opr = '0;
      logic [47:0] p  = 48'h0000_5EED_F00D;
      logic [47:0] x_mux, z_mux;

      dsp_mac_sequencer #(.N_TAPS(NT), .CNT_W(10)) u_dut (
         .CLK(clk), .RSTN(rst_n),
         .S_VALID(s_valid), .S_READY(s_ready_l), .S_A(s_a), .S_B(s_b),
         .R_VALID(r_valid_l), .R_READY(r_ready), .R_DATA(r_data_l),
         .DSP_A(a_l), .DSP_B(b_l), .DSP_OPMODE(op_l), .DSP_CE(ce_l),
         .DSP_P(p)
      );

      // Slice model: A1/B1 -> M -> P. OPMODE is registered. The slice is never reset.
      always_comb begin
         x_mux = (opr[1:0] == 2'b01) ? {12'd0, m} : 48'd0;
         z_mux = (opr[3:2] == 2'b10) ? p : 48'd0;
      end
      always @(posedge clk) begin
         if (ce_l) begin
            a1  <= a_l;
            b1  <= b_l;
            m   <= a1 * b1;
            opr <= op_l;
            p   <= z_mux + x_mux;
         end
      end

      assign s_ready_w[g] = s_ready_l;
      assign r_valid_w[g] = r_valid_l;
      assign r_data_w[g]  = r_data_l;
      assign dsp_a_w[g]   = a_l;
      assign dsp_b_w[g]   = b_l;
      assign dsp_op_w[g]  = op_l;
      assign dsp_ce_w[g]  = ce_l;
   end

   // Result collector for the instance under test
   always @(negedge clk) begin
      if (rst_n && r_valid_w[sel] && r_ready) begin
         got_q.push_back(r_data_w[sel]);
         got_cyc.push_back(cyc);
      end
   end

   task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      s_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      got_q.delete();
      got_cyc.delete();
   endtask

   task automatic send_pair(input logic [17:0] a, input logic [17:0] b);
      bit ok = 1'b0;
      s_valid = 1'b1;
      s_a     = a;
      s_b     = b;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         ok = s_ready_w[sel];
         tick();
      end
      if (ok) last_acc = cyc;
      else check("accept", 48'(ok), 48'd1);
   endtask

   task automatic idle(input int n);
      s_valid = 1'b0;
      s_a     = '0;
      s_b     = '0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wait_results(input string tag, input int n);
      for (int i = 0; i < 60 && got_q.size() < n; i++) tick();
      check({tag, "_count"}, 48'(got_q.size()), 48'(n));
   endtask

   function automatic logic [47:0] got_at(input int i);
      return (i < got_q.size()) ? got_q[i] : 48'hFFFF_FFFF_FFFF;
   endfunction

   task automatic send_basic();
      send_pair(18'd1, 18'd2);
      send_pair(18'd3, 18'd4);
      send_pair(18'd5, 18'd6);
      send_pair(18'd7, 18'd8);
   endtask

   initial begin
      rst_n   = 1'b0;
      s_valid = 1'b0;
      s_a     = '0;
      s_b     = '0;
      r_ready = 1'b1;

      // Reset state
      #12;
      check("rst_r_valid", 48'(r_valid_w[0]), 48'd0);
      check("rst_r_data",  r_data_w[0], 48'd0);
      check("rst_s_ready", 48'(s_ready_w[0]), 48'd0);
      check("rst_dsp_a",   48'(dsp_a_w[0]), 48'd0);
      check("rst_dsp_b",   48'(dsp_b_w[0]), 48'd0);
      check("rst_opmode",  48'(dsp_op_w[0]), 48'd0);
      check("rst_dsp_ce",  48'(dsp_ce_w[0]), 48'd0);
      tick();
      rst_n = 1'b1;
      tick();
      check("ce_after_rst", 48'(dsp_ce_w[0]), 48'd1);
      check("opm_bubble",   48'(dsp_op_w[0]), 48'h08);

      // N_TAPS=4, one vector
      sel = 0;
      do_reset();
      send_basic();
      idle(1);
      wait_results("t1", 1);
      check("t1_sum", got_at(0), 48'd100);
      check("t1_latency", 48'(got_cyc.size() > 0 ? got_cyc[0] : -1), 48'(last_acc + 4));
      idle(5);
      check("t1_one_cycle", 48'(got_q.size()), 48'd1);
      check("t1_rvalid_low", 48'(r_valid_w[0]), 48'd0);

      // N_TAPS=4, two vectors back-to-back
      do_reset();
      send_basic();
      for (int i = 0; i < 4; i++) send_pair(18'd1, 18'd1);
      idle(1);
      wait_results("t2", 2);
      check("t2_sum0", got_at(0), 48'd100);
      check("t2_sum1", got_at(1), 48'd4);
      check("t2_spacing", 48'(got_cyc.size() > 1 ? got_cyc[1] - got_cyc[0] : -1), 48'd4);

      // N_TAPS=4, two-cycle bubble mid-vector
      do_reset();
      send_pair(18'd1, 18'd2);
      send_pair(18'd3, 18'd4);
      idle(2);
      send_pair(18'd5, 18'd6);
      send_pair(18'd7, 18'd8);
      idle(1);
      wait_results("t3", 1);
      check("t3_sum", got_at(0), 48'd100);
      idle(3);

      // Reset pulse mid-vector; DUT0 still holds the 100 from the previous test
      got_q.delete();
      got_cyc.delete();
      send_pair(18'd9, 18'd9);
      send_pair(18'd9, 18'd9);
      rst_n = 1'b0;
      s_valid = 1'b0;
      #1;
      check("t5_r_valid", 48'(r_valid_w[0]), 48'd0);
      check("t5_r_data",  r_data_w[0], 48'd0);
      check("t5_s_ready", 48'(s_ready_w[0]), 48'd0);
      check("t5_dsp_a",   48'(dsp_a_w[0]), 48'd0);
      check("t5_dsp_b",   48'(dsp_b_w[0]), 48'd0);
      check("t5_opmode",  48'(dsp_op_w[0]), 48'd0);
      check("t5_dsp_ce",  48'(dsp_ce_w[0]), 48'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check("t5_ce_on", 48'(dsp_ce_w[0]), 48'd1);
      send_basic();
      idle(1);
      wait_results("t5", 1);
      check("t5_sum", got_at(0), 48'd100);
      idle(6);
      check("t5_no_extra", 48'(got_q.size()), 48'd1);

      // N_TAPS=2 with backpressure
      sel = 1;
      r_ready = 1'b0;
      do_reset();
      send_pair(18'd1, 18'd1);
      send_pair(18'd1, 18'd1);
      send_pair(18'd2, 18'd2);
      send_pair(18'd2, 18'd2);
      send_pair(18'd3, 18'd3);
      send_pair(18'd3, 18'd3);
      idle(8);
      check("t4_held_valid", 48'(r_valid_w[1]), 48'd1);
      check("t4_held_data",  r_data_w[1], 48'd2);
      check("t4_s_ready",    48'(s_ready_w[1]), 48'd0);
      check("t4_dsp_ce",     48'(dsp_ce_w[1]), 48'd0);
      r_ready = 1'b1;
      wait_results("t4", 3);
      check("t4_sum0", got_at(0), 48'd2);
      check("t4_sum1", got_at(1), 48'd8);
      check("t4_sum2", got_at(2), 48'd18);
      idle(3);
      check("t4_s_ready_back", 48'(s_ready_w[1]), 48'd1);

      // N_TAPS=1, full-scale product then a small one
      sel = 2;
      do_reset();
      send_pair(18'h3FFFF, 18'h3FFFF);
      send_pair(18'd2, 18'd3);
      idle(1);
      wait_results("t6", 2);
      check("t6_sum0", got_at(0), 48'h000F_FFF8_0001);
      check("t6_sum1", got_at(1), 48'd6);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
